// File: rtl/prbs_frame_gen_pkg.sv
// Shared types and constants for the PRBS frame generator.
// Optional sequence-number prefix is enabled by PRBS_FRAME_SEQNUM_EN.
package prbs_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned LANE_HI = 31;
  localparam int unsigned LANE_LO = 24;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(3);

`ifdef PRBS_FRAME_SEQNUM_EN
  localparam int unsigned SEQ_W = 16;
`endif

  // Byte presented on the stream: the word is sent MSB lane first.
  function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] w);
    return w[LANE_HI:LANE_LO];
  endfunction

endpackage

// File: rtl/prbs_frame_gen_if.sv
// Control and byte-stream bundle between the PRBS frame generator and its host/sink.
interface prbs_frame_gen_if
  import prbs_frame_gen_pkg::*;
#(
  parameter int unsigned LEN_W = 11,
  parameter int unsigned CNT_W = 16
);
  logic [WORD_W-1:0] mseq32;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    input  mseq32, start, frame_len, tx_ready,
    output tx_data, tx_valid, tx_last, busy, frame_cnt
  );

  modport slave (
    output mseq32, start, frame_len, tx_ready,
    input  tx_data, tx_valid, tx_last, busy, frame_cnt
  );
endinterface

// File: rtl/prbs_word_shifter.sv
// 32-bit PRBS capture/shift register with frame byte counter and lane tracking.
module prbs_word_shifter
  import prbs_frame_gen_pkg::*;
#(
  parameter int unsigned LEN_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic              i_shift_en,
  input  logic [WORD_W-1:0] i_mseq32,
  output logic [BYTE_W-1:0] o_byte,
  output logic [LEN_W-1:0]  o_byte_cnt
);

  logic [WORD_W-1:0] r_word;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [LANE_W-1:0] r_lane;
  logic              w_reload;

  // Leaving the last lane of a word pulls in a fresh m-sequence word.
  assign w_reload = i_adv && i_shift_en && (r_lane == LANE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_lane     <= '0;
    end else if (i_load) begin
      r_word     <= i_mseq32;
      r_byte_cnt <= '0;
      r_lane     <= '0;
    end else if (i_adv) begin
      r_byte_cnt <= r_byte_cnt + LEN_W'(1);
      if (i_shift_en) begin
        r_lane <= r_lane + LANE_W'(1);
        r_word <= w_reload ? i_mseq32 : {r_word[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      end
    end
  end

  assign o_byte     = msb_byte(r_word);
  assign o_byte_cnt = r_byte_cnt;

endmodule

// File: rtl/prbs_frame_gen.sv
// PRBS test-frame generator: host-sized frames from the m-sequence word, then an idle gap.
// Define PRBS_FRAME_SEQNUM_EN to prefix each frame with a 16-bit sequence number.
module prbs_frame_gen
  import prbs_frame_gen_pkg::*;
#(
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  prbs_frame_gen_if.master  bus
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  state_e            r_state;
  logic [LEN_W-1:0]  r_len;
  logic              r_tx_valid;
  logic              r_tx_last;
  logic              r_busy;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic              w_accept;
  logic              w_start_ok;
  logic              w_next_last;
  logic              w_shift_en;
  logic [BYTE_W-1:0] w_word_byte;
  logic [LEN_W-1:0]  w_byte_cnt;

  assign w_accept    = r_tx_valid && bus.tx_ready;
  assign w_start_ok  = (r_state == ST_IDLE) && bus.start && (bus.frame_len != '0);
  assign w_next_last = (w_byte_cnt + LEN_W'(1)) == (r_len - LEN_W'(1));

  prbs_word_shifter #(.LEN_W(LEN_W)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_ok),
    .i_adv      (w_accept && !r_tx_last),
    .i_shift_en (w_shift_en),
    .i_mseq32   (bus.mseq32),
    .o_byte     (w_word_byte),
    .o_byte_cnt (w_byte_cnt)
  );

`ifdef PRBS_FRAME_SEQNUM_EN
  logic [SEQ_W-1:0] r_seq;
  logic             r_in_seq;

  // The PRBS word stays parked while the two sequence bytes go out.
  assign w_shift_en  = !r_in_seq;
  assign bus.tx_data = r_in_seq ? r_seq[SEQ_W-1 -: BYTE_W] : w_word_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq    <= '0;
      r_in_seq <= 1'b0;
    end else if (w_start_ok) begin
      r_seq    <= SEQ_W'(r_frame_cnt);
      r_in_seq <= 1'b1;
    end else if (w_accept && r_in_seq) begin
      r_seq    <= r_seq << BYTE_W;
      r_in_seq <= !r_tx_last && (w_byte_cnt == '0);
    end
  end
`else
  assign w_shift_en  = 1'b1;
  assign bus.tx_data = w_word_byte;
`endif

  // Frame sequencing: IDLE -> SEND -> GAP (skipped when IFG_CYCLES is 0) -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len      <= bus.frame_len;
            r_tx_valid <= 1'b1;
            r_tx_last  <= (bus.frame_len == LEN_W'(1));
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (r_tx_last) begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              r_tx_valid  <= 1'b0;
              r_tx_last   <= 1'b0;
              r_gap_cnt   <= '0;
              if (IFG_CYCLES > 0) begin
                r_state <= ST_GAP;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tx_last <= w_next_last;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_END) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_last   = r_tx_last;
  assign bus.busy      = r_busy;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_prbs_frame_gen.sv
// Self-checking bench for prbs_frame_gen: known-answer frame table plus scoreboarded corner sequences.
module tb_prbs_frame_gen;

  localparam int unsigned LEN_W = 11;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IFG   = 12;
`ifdef PRBS_FRAME_SEQNUM_EN
  localparam int SEQ = 2;
`else
  localparam int SEQ = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;
    int          cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prbs_frame_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  prbs_frame_gen #(.LEN_W(LEN_W), .IFG_CYCLES(IFG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_edge = 0;
  int          acc_cnt = 0;
  int          acc0 = 0;
  int          exp_cnt = 0;
  exp_t        sb[$];
  vec_t        tv[5];
  bit          model_on = 1'b0;
  bit          free_run = 1'b0;
  int          mlen = 0;
  int          mb = 0;
  logic [31:0] lfsr = 32'h1;
  bit          stall_pend = 1'b0;
  logic [7:0]  stall_d;
  logic        stall_l;
  logic [63:0] ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int first);
    for (int k = 0; k < 4; k++) begin
      if (first + k < mlen) sb.push_back('{w[31-8*k -: 8], (first + k) == (mlen - 1)});
    end
  endtask

  // Reference model for a frame whose later words come from the live mseq32 input.
  task automatic start_model(input int len, input logic [31:0] w0);
    logic [15:0] s;
    s        = 16'(exp_cnt);
    model_on = 1'b1;
    mlen     = len;
    mb       = 0;
    if (SEQ > 0) begin
      sb.push_back('{s[15:8], len == 1});
      if (len >= 2) sb.push_back('{s[7:0], len == 2});
    end
    push_word(w0, SEQ);
  endtask

  // Inspect the cycle whose inputs are already set; the accept lands on the coming edge.
  task automatic observe();
    exp_t e;
    int   b;
    if (reset) begin
      stall_pend = 1'b0;
      return;
    end
    if (stall_pend) begin
      check("stall_valid", bus.tx_valid, 1'b1);
      check("stall_data", bus.tx_data, stall_d);
      check("stall_last", bus.tx_last, stall_l);
    end
    stall_pend = bus.tx_valid && !bus.tx_ready;
    stall_d    = bus.tx_data;
    stall_l    = bus.tx_last;
    if (bus.tx_valid && bus.tx_ready) begin
      acc_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.tx_data);
      end else begin
        e = sb.pop_front();
        check("tx_data", bus.tx_data, e.data);
        check("tx_last", bus.tx_last, e.last);
      end
      if (bus.tx_last) last_edge = cyc + 1;
      if (model_on) begin
        b = mb;
        mb++;
        if (b >= SEQ && ((b - SEQ) % 4) == 3 && (b + 1) < mlen) push_word(bus.mseq32, b + 1);
      end
    end
  endtask

  task automatic next_cycle();
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input string nm, input bit rnd, input bit hold_start);
    for (int k = 0; k < 2000; k++) begin
      if (!bus.busy) break;
      if (rnd) bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (free_run) begin
        lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        bus.mseq32 = lfsr;
      end
      bus.start = hold_start;
      if (hold_start) bus.frame_len = LEN_W'(5);
      next_cycle();
    end
    bus.start    = 1'b0;
    bus.tx_ready = 1'b1;
    check({nm, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic launch_model(input int len);
    free_run      = 1'b1;
    lfsr          = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    bus.mseq32    = lfsr;
    bus.start     = 1'b1;
    bus.frame_len = LEN_W'(len);
    start_model(len, lfsr);
    acc0 = acc_cnt;
    next_cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
`ifdef PRBS_FRAME_SEQNUM_EN
    tv[0] = '{6, 32'h789ABCDE, 32'hF13579BD, 64'h0000_789A_BCDE_0000, 1};
    tv[1] = '{6, 32'h789ABCDE, 32'hF13579BD, 64'h0001_789A_BCDE_0000, 2};
    tv[2] = '{1, 32'h5A6B7C8D, 32'h00000000, 64'h0000_0000_0000_0000, 3};
    tv[3] = '{8, 32'h01234567, 32'h89ABCDEF, 64'h0003_0123_4567_89AB, 4};
    tv[4] = '{3, 32'hDEADBEEF, 32'h00000000, 64'h0004_DE00_0000_0000, 5};
`else
    tv[0] = '{4, 32'h789ABCDE, 32'hF13579BD, 64'h789A_BCDE_0000_0000, 1};
    tv[1] = '{6, 32'h789ABCDE, 32'hF13579BD, 64'h789A_BCDE_F135_0000, 2};
    tv[2] = '{1, 32'h5A6B7C8D, 32'h00000000, 64'h5A00_0000_0000_0000, 3};
    tv[3] = '{8, 32'h01234567, 32'h89ABCDEF, 64'h0123_4567_89AB_CDEF, 4};
    tv[4] = '{3, 32'hDEADBEEF, 32'h00000000, 64'hDEAD_BE00_0000_0000, 5};
`endif
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.mseq32    = '0;
    bus.tx_ready  = 1'b1;
    repeat (3) next_cycle();
    check("rst_valid", bus.tx_valid, 1'b0);
    check("rst_last", bus.tx_last, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_cnt", bus.frame_cnt, 16'h0000);
    reset = 1'b0;

    // Known-answer frames, first one requested in the first cycle after reset release.
    for (int v = 0; v < 5; v++) begin
      model_on      = 1'b0;
      free_run      = 1'b0;
      bus.start     = 1'b1;
      bus.frame_len = LEN_W'(tv[v].len);
      bus.mseq32    = tv[v].w0;
      ev            = tv[v].exp;
      for (int i = 0; i < tv[v].len; i++) sb.push_back('{ev[63-8*i -: 8], i == tv[v].len - 1});
      next_cycle();
      bus.start  = 1'b0;
      bus.mseq32 = tv[v].w1;
      run_until_idle($sformatf("vec%0d", v), 1'b0, 1'b0);
      exp_cnt++;
      check($sformatf("vec%0d_frame_cnt", v), bus.frame_cnt, tv[v].cnt);
      check($sformatf("vec%0d_gap", v), cyc - last_edge, IFG);
      check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
    end

    // 64-byte frame with random back-pressure and a free-running m-sequence.
    launch_model(64);
    run_until_idle("stall64", 1'b1, 1'b0);
    exp_cnt++;
    check("stall64_accepts", acc_cnt - acc0, 64);
    check("stall64_frame_cnt", bus.frame_cnt, exp_cnt);
    check("stall64_sb_empty", sb.size(), 0);

    // start held through SEND and GAP must not queue another frame.
    launch_model(8);
    run_until_idle("start_ign", 1'b0, 1'b1);
    exp_cnt++;
    check("start_ign_accepts", acc_cnt - acc0, 8);
    check("start_ign_frame_cnt", bus.frame_cnt, exp_cnt);
    next_cycle();
    check("start_ign_no_new_busy", bus.busy, 1'b0);
    check("start_ign_no_new_valid", bus.tx_valid, 1'b0);

    // Zero-length request is dropped.
    bus.start     = 1'b1;
    bus.frame_len = '0;
    next_cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("len0_busy", bus.busy, 1'b0);
      check("len0_valid", bus.tx_valid, 1'b0);
      next_cycle();
    end
    check("len0_frame_cnt", bus.frame_cnt, exp_cnt);

    // Asynchronous reset in the middle of a 20-byte frame.
    launch_model(20);
    for (int k = 0; k < 200 && (acc_cnt - acc0) < 10; k++) next_cycle();
    check("mid_rst_reach10", acc_cnt - acc0, 10);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.tx_valid, 1'b0);
    check("mid_rst_last", bus.tx_last, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_data", bus.tx_data, 8'h00);
    check("mid_rst_cnt", bus.frame_cnt, 16'h0000);
    sb.delete();
    model_on = 1'b0;
    exp_cnt  = 0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    launch_model(20);
    run_until_idle("post_rst", 1'b0, 1'b0);
    exp_cnt++;
    check("post_rst_accepts", acc_cnt - acc0, 20);
    check("post_rst_frame_cnt", bus.frame_cnt, exp_cnt);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_frame_gen.md
Name: prbs_frame_gen

Overview:
Consumes the free-running 32-bit m-sequence word and turns it into byte-wide PRBS test frames on a valid/ready byte stream. It sits directly downstream of the m-sequence generator and upstream of the MAC TX path (preamble/FCS insertion lives downstream of this block). Each frame is a host-programmed length followed by a fixed idle gap.

Parameters:
LEN_W, 11, width of frame_len (max frame 2^LEN_W-1 bytes)
IFG_CYCLES, 12, idle cycles enforced after each frame's last byte (0 = none)
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
mseq32  in  32  free-running m-sequence word (new value every cycle)
start  in  1  request one frame; sampled only in IDLE
frame_len  in  LEN_W  frame length in bytes; sampled with start
tx_data  out  8  payload byte
tx_valid  out  1  tx_data valid
tx_last  out  1  marks final byte of frame (qualified by tx_valid)
tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready
busy  out  1  high in SEND or GAP
frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W

Behaviour:
- Reset (async, any state, mid-frame included): state=IDLE; tx_valid, tx_last, busy, tx_data, frame_cnt, internal counters and shift word = 0. The partial frame is discarded, with no tx_last.
- States: IDLE, SEND, GAP.
- IDLE: start=1 && frame_len!=0 -> latch len, capture word<=mseq32, byte_cnt<=0, go SEND. tx_valid=1 from the next cycle (1-cycle latency). start with frame_len=0 is ignored.
- SEND: tx_valid=1; tx_data=word[31:24] (MSB byte first); tx_last=(byte_cnt==len-1).
- Accept = tx_valid && tx_ready. On accept: byte_cnt++ and word<<=8.
- On the accept of byte 3 of a word (byte_cnt[1:0]==3, not last), word<=mseq32 sampled on that same edge.
- While tx_valid && !tx_ready: tx_data, tx_last and word hold. tx_valid never deasserts before accept. mseq32 changes are ignored.
- On accept with tx_last: frame_cnt++ (wraps). Go GAP if IFG_CYCLES>0, else IDLE. tx_valid=0 next cycle.
- GAP: tx_valid=0; count IFG_CYCLES cycles, then IDLE. The first IDLE cycle can accept start.
- start in SEND/GAP is ignored, not queued. frame_len changes after capture have no effect.
- Non-multiple-of-4 lengths: the unused bytes of the final word are dropped.

Optional Feature:
PRBS_FRAME_SEQNUM_EN
- Defined: bytes 0 and 1 of each frame are a 16-bit sequence number (= frame_cnt[15:0] at frame start, MSB first). The word does not shift during those bytes. PRBS bytes start at byte 2 using the word captured at start. Word reload occurs after every 4 PRBS bytes. frame_len counts the sequence bytes: len 1 sends only the seq MSB; len 2 sends only the seq number.
- Undefined: all bytes are PRBS as above. No sequence logic is synthesised.

Decomposition:
- Shared package: state encoding (ST_IDLE/ST_SEND/ST_GAP) and the byte-lane index constants.
- Natural sub-module: prbs_word_shifter (32-bit capture/shift register with byte_cnt and reload-request). The FSM and gap counter stay in the top module.

Test Plan:
1. Release reset, start=1 with frame_len=4 in the first cycle after release (mseq32=32'h789ABCDE), tx_ready=1 -> tx_data 78,9A,BC,DE on 4 consecutive cycles; tx_last only on DE; frame_cnt=1; busy low exactly IFG_CYCLES=12 cycles after DE.
2. Same setup but frame_len=6 -> bytes 78,9A,BC,DE,F1,35 (the next word 32'hF13579BD sampled at the DE accept); tx_last on 35.
3. Randomised tx_ready stalls during a 64-byte frame -> tx_data/tx_last stable during stalls; byte sequence matches a bench LFSR model sampled only at word-reload accepts; exactly 64 accepts.
4. start pulsed during SEND and during GAP -> ignored; frame_cnt increments only once. start with frame_len=0 in IDLE -> no tx_valid, busy stays 0.
5. Assert reset at byte 10 of a 20-byte frame -> all outputs 0 asynchronously, frame_cnt=0; a new start after release sends a complete frame.
6. With PRBS_FRAME_SEQNUM_EN, two back-to-back frames of len=6 -> frame 1 starts 00,00 then 4 PRBS bytes; frame 2 starts 00,01.
